lsu_memaccess: RTL and testbench

//  Load/store unit: the initiator side of the data-memory interface. Takes one load/store per

---
 rtl/lsu_memaccess.sv | 188 ++++++++++++++++++
 tb/tb_lsu_memaccess.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_memaccess.sv
// lsu_memaccess: load/store unit, initiator side of the word-addressed data-memory port.
// Latency: zero-wait ack gives rsp_valid two cycles after accept; errors respond one cycle after accept.
// Backpressure: one op in flight, req_ready only in IDLE; rsp_valid is a one-cycle pulse, never stalled.
//
// Ports:
//   clk, rst                       core clock, async active-high reset
//   req_valid/req_ready            execute-stage handshake; req_we/funct3/addr/wdata captured at accept
//   rsp_valid/rsp_rdata/rsp_err    completion pulse with extended load data or error flag
//   mem_req/we/addr/wdata/be       memory request, held until mem_ack or timeout
//   mem_ack/mem_rdata              memory completion and read word
module lsu_memaccess #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter must hold TIMEOUT-1; never narrower than 4 bits.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               accept;
    logic               acc_err;
    logic               in_req;
    logic [31:0]        shifted;
    logic [31:0]        load_data;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign in_req    = (state_q == S_REQ);

    // Request legality, evaluated on the live inputs in the accept cycle.
    always_comb begin
        acc_err = 1'b0;
        unique case (req_funct3)
            3'b000: acc_err = 1'b0;
            3'b001: acc_err = req_addr[0];
            3'b010: acc_err = |req_addr[1:0];
            3'b100: acc_err = req_we;
            3'b101: acc_err = req_we | req_addr[0];
            default: acc_err = 1'b1;
        endcase
        if (|req_addr[31:ADDR_W+2]) begin
            acc_err = 1'b1;
        end
    end

    // Lane placement from the captured request.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata_q;
            end
        endcase
    end

    // Addressed byte/half lands in the low bits, then extend per funct3.
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = shifted;
        unique case (f3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                // Ack takes priority over the timeout on the last counted cycle.
                if (mem_ack) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    // Memory-side outputs are forced to zero outside REQ so nothing leaks during reset or idle.
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_addr  = in_req ? addr_q[ADDR_W+1:2] : '0;
    assign mem_be    = in_req ? be_c : 4'b0000;
    assign mem_wdata = (in_req && we_q) ? wdata_c : 32'd0;

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_memaccess.sv
`timescale 1ns/1ps
module tb_lsu_memaccess;

    localparam int AW    = 9;
    localparam int TO    = 15;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    lsu_memaccess #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected outputs for the current cycle, set by the stimulus side.
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_mreq, exp_mwe, exp_rv, exp_rerr;
    logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
    logic [3:0]  exp_mbe;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what an RV32I load/store must do, in plain arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rd,
                                  output logic err, output logic [3:0] be,
                                  output logic [31:0] waddr, output logic [31:0] wrep,
                                  output logic [31:0] res);
        int nb;
        int off;
        bit sgn;
        bit legal;
        logic [31:0] v;
        logic [31:0] mask;
        off = int'(addr % 4);
        nb = 1; sgn = 0; legal = 1;
        case (f3)
            3'd0: begin nb = 1; sgn = 1; end
            3'd1: begin nb = 2; sgn = 1; end
            3'd2: begin nb = 4; end
            3'd4: begin nb = 1; legal = !we; end
            3'd5: begin nb = 2; legal = !we; end
            default: legal = 0;
        endcase
        err   = !legal || ((off % nb) != 0) || (addr >= 32'(4 * DEPTH));
        be    = 4'(((1 << nb) - 1) << off);
        waddr = (addr / 4) % DEPTH;
        wrep  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            wrep |= ((wd >> (8 * (i % nb))) & 32'hff) << (8 * i);
        end
        mask = (nb == 4) ? 32'hffff_ffff : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rd >> (8 * off)) & mask;
        if (sgn && nb < 4 && v[8*nb-1]) v |= ~mask;
        res = (we || err) ? 32'd0 : v;
    endfunction

    // Single compare process: every cycle while enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err",   {31'd0, rsp_err},   {31'd0, exp_rerr});
            chk("mem_req",   {31'd0, mem_req},   {31'd0, exp_mreq});
            if (exp_mreq) begin
                chk("mem_we",   {31'd0, mem_we}, {31'd0, exp_mwe});
                chk("mem_addr", {23'd0, mem_addr}, exp_maddr);
                chk("mem_be",   {28'd0, mem_be}, {28'd0, exp_mbe});
                if (exp_mwe) chk("mem_wdata", mem_wdata, exp_mwdata);
            end
        end
    end

    task automatic set_idle_exp();
        exp_ready = 1'b1; exp_mreq = 1'b0; exp_rv = 1'b0;
        exp_mwe = 1'b0; exp_maddr = '0; exp_mwdata = '0; exp_mbe = '0;
        exp_rdata = last_rdata; exp_rerr = last_err;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
        end
    endtask

    // wait_n: number of REQ cycles with ack low before ack; negative = never ack.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
        logic err;
        logic [3:0] be;
        logic [31:0] waddr, wrep, res;
        bit done;
        model(we, f3, addr, wd, rd, err, be, waddr, wrep, res);
        set_idle_exp();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        tick();
        // Scramble inputs: the LSU must hold its captured copy.
        req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        exp_ready = 1'b0;
        if (!err) begin
            exp_mreq = 1'b1; exp_mwe = we; exp_maddr = waddr; exp_mbe = be; exp_mwdata = wrep;
            done = 0;
            for (int k = 0; k < TO && !done; k++) begin
                mem_ack   = (k == wait_n);
                mem_rdata = mem_ack ? rd : $urandom;
                if (k == wait_n) done = 1;
                tick();
            end
            last_err   = !done;
            last_rdata = done ? res : 32'd0;
        end else begin
            last_err   = 1'b1;
            last_rdata = 32'd0;
        end
        exp_mreq = 1'b0; exp_rv = 1'b1; exp_rdata = last_rdata; exp_rerr = last_err;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        tick();
        set_idle_exp();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic e; logic [3:0] b; logic [31:0] wa, wr, rs;
        logic we_r; logic [2:0] f3_r; logic [31:0] a_r; int r; int w;

        // Pin the model with hand-computed values.
        model(0, 3'b000, 32'h13, 32'h0, 32'h80FF1234, e, b, wa, wr, rs);
        chk("pin_lb", rs, 32'hFFFFFF80); chk("pin_lb_be", {28'd0, b}, 32'h8);
        model(0, 3'b100, 32'h13, 32'h0, 32'h80FF1234, e, b, wa, wr, rs);
        chk("pin_lbu", rs, 32'h00000080);
        model(0, 3'b001, 32'h02, 32'h0, 32'h80017FFF, e, b, wa, wr, rs);
        chk("pin_lh", rs, 32'hFFFF8001);
        model(1, 3'b001, 32'h06, 32'h0000ABCD, 32'h0, e, b, wa, wr, rs);
        chk("pin_sh_wd", wr, 32'hABCDABCD); chk("pin_sh_be", {28'd0, b}, 32'hC);
        chk("pin_sh_wa", wa, 32'd1);
        model(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, e, b, wa, wr, rs);
        chk("pin_sw_wa", wa, 32'd4); chk("pin_sw_err", {31'd0, e}, 32'd0);
        model(0, 3'b010, 32'h800, 32'h0, 32'h0, e, b, wa, wr, rs);
        chk("pin_oor", {31'd0, e}, 32'd1);

        // Reset state: all outputs low while rst is high.
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mreq", {31'd0, mem_req}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        tick();
        rst = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        idle(2);

        // Directed cases.
        run_op(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2);
        run_op(0, 3'b000, 32'h13, 32'h0, 32'h80FF1234, 0);
        run_op(0, 3'b100, 32'h13, 32'h0, 32'h80FF1234, 1);
        run_op(0, 3'b001, 32'h02, 32'h0, 32'h80017FFF, 0);
        run_op(1, 3'b001, 32'h06, 32'h0000ABCD, 32'h0, 0);
        run_op(0, 3'b010, 32'h05, 32'h0, 32'h0, 0);
        run_op(1, 3'b001, 32'h01, 32'h0, 32'h0, 0);
        run_op(1, 3'b100, 32'h00, 32'h0, 32'h0, 0);
        run_op(0, 3'b010, 32'h800, 32'h0, 32'h0, 0);
        run_op(0, 3'b010, 32'h0, 32'h0, 32'h12345678, -1);
        run_op(0, 3'b010, 32'h0, 32'h0, 32'h12345678, TO - 1);
        run_op(0, 3'b010, 32'h0, 32'h0, 32'h12345678, TO);

        // Reset in the middle of REQ: request dropped, no response.
        chk_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        mem_ack = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_mreq_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_mreq_rst", {31'd0, mem_req}, 32'd0);
        chk("mid_ready_rst", {31'd0, req_ready}, 32'd0);
        chk("mid_rv_rst", {31'd0, rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        last_rdata = 32'd0; last_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("post_rst_rv", {31'd0, rsp_valid}, 32'd0);
            chk("post_rst_mreq", {31'd0, mem_req}, 32'd0);
        end
        tick();
        set_idle_exp();
        chk_en = 1'b1;
        run_op(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            we_r = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0) f3_r = 3'($urandom);
            else if (we_r) f3_r = 3'($urandom_range(0, 2));
            else begin
                r = $urandom_range(0, 4);
                f3_r = (r > 2) ? 3'(r + 1) : 3'(r);
            end
            r = $urandom_range(0, 19);
            if (r == 0) a_r = $urandom;
            else begin
                a_r = 32'($urandom_range(0, 4 * DEPTH - 1));
                if (r < 15 && f3_r[1:0] != 2'b11) a_r &= ~((32'd1 << f3_r[1:0]) - 32'd1);
            end
            r = $urandom_range(0, 9);
            if (r == 0) w = -1;
            else if (r == 1) w = TO - 1;
            else w = $urandom_range(0, 3);
            run_op(we_r, f3_r, a_r, $urandom, $urandom, w);
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
